cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge_if.sv | 33 +++
 rtl/cpu_mem_bridge.sv | 105 ++++++++++
 tb/tb_cpu_mem_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_if.sv
// CPU request/response and memory access signals shared by the bridge and its environment.
// The slave modport is the bridge's view; the master modport is the CPU plus memory side.
interface cpu_mem_bridge_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output mem_rden, mem_wren, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  mem_rden, mem_wren, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Bridges single outstanding CPU byte-addressed requests onto a word-indexed memory port,
// with range checking, a response timeout and a saturating error counter.
module cpu_mem_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MEM_WORDS = 16384,
  parameter int          TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  conf_sel,
  output logic [15:0]           err_cnt,
  cpu_mem_bridge_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [32:0] MemWordsW = 33'(MEM_WORDS);
  localparam logic [7:0]  TmoLast   = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  tmoCnt_q;
  logic [15:0] errCnt_q;
  logic [15:0] errCnt_d;
  logic [31:0] offset;
  logic [31:0] wordIdx;
  logic        inRange;

  // Addresses below the base are rejected outright, so the subtraction never wraps into range.
  always_comb begin
    offset   = bus.cpu_addr - ADDR_BASE;
    wordIdx  = {2'b00, offset[31:2]};
    inRange  = (bus.cpu_addr >= ADDR_BASE) && ({1'b0, wordIdx} < MemWordsW);
    errCnt_d = (errCnt_q == 16'hFFFF) ? errCnt_q : errCnt_q + 16'd1;
  end

  assign err_cnt = errCnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tmoCnt_q      <= 8'd0;
      errCnt_q      <= 16'd0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= 32'd0;
      bus.mem_rden  <= 1'b0;
      bus.mem_wren  <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wstrb <= 4'd0;
      bus.mem_wdata <= 32'd0;
    end else begin
      bus.mem_rden <= 1'b0;
      bus.mem_wren <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_valid && !conf_sel) begin
            if (inRange) begin
              bus.mem_addr  <= wordIdx;
              bus.mem_wstrb <= bus.cpu_wstrb;
              bus.mem_wdata <= bus.cpu_wdata;
              bus.mem_rden  <= (bus.cpu_wstrb == 4'd0);
              bus.mem_wren  <= (bus.cpu_wstrb != 4'd0);
              state_q       <= ISSUE;
            end else begin
              bus.cpu_ready <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= 32'd0;
              errCnt_q      <= errCnt_d;
              state_q       <= RESP;
            end
          end
        end
        ISSUE: begin
          tmoCnt_q <= 8'd0;
          state_q  <= WAIT;
        end
        // A response arriving in the final wait cycle still wins over the timeout.
        WAIT: begin
          if (bus.mem_ready) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= (bus.mem_wstrb == 4'd0) ? bus.mem_rdata : 32'd0;
            state_q       <= RESP;
          end else if (tmoCnt_q == TmoLast) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= 32'd0;
            errCnt_q      <= errCnt_d;
            state_q       <= RESP;
          end else begin
            tmoCnt_q <= tmoCnt_q + 8'd1;
          end
        end
        RESP: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_rdata <= 32'd0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed checks of the CPU-to-memory bridge with a two-cycle-latency memory model.
module tb_cpu_mem_bridge;

  logic        clk;
  logic        reset;
  logic        conf_sel;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic        p0, p1, p2;
  logic        memAuto;
  logic        forceReady;
  logic [31:0] memData;
  int          pulses;
  int          readies;
  int          lat;

  cpu_mem_bridge_if bus ();

  cpu_mem_bridge #(
    .ADDR_BASE(32'h0000_0000),
    .MEM_WORDS(16384),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .conf_sel(conf_sel),
    .err_cnt(err_cnt),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=expired expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [3:0] wstrb, input logic [31:0] wdata);
    bus.cpu_valid = valid;
    bus.cpu_addr  = addr;
    bus.cpu_wstrb = wstrb;
    bus.cpu_wdata = wdata;
  endtask

  // Advance one cycle and run the memory model: mem_ready follows a pulse by two cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    p2 = p1;
    p1 = p0;
    p0 = bus.mem_rden | bus.mem_wren;
    if (p0) pulses++;
    if (bus.cpu_ready === 1'b1) readies++;
    bus.mem_ready = (memAuto & p2) | forceReady;
    bus.mem_rdata = memData;
  endtask

  task automatic waitReady(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.cpu_ready !== 1'b1 && cycles < budget);
    checkOutput("readySeen", {31'd0, bus.cpu_ready}, 32'd1);
  endtask

  initial begin
    p0 = 0; p1 = 0; p2 = 0;
    memAuto = 1; forceReady = 0; memData = 32'd0;
    pulses = 0; readies = 0;
    reset = 1'b1;
    conf_sel = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);

    tick(); tick();
    checkOutput("rstReady", {31'd0, bus.cpu_ready}, 32'd0);
    checkOutput("rstRden", {31'd0, bus.mem_rden}, 32'd0);
    checkOutput("rstErrCnt", {16'd0, err_cnt}, 32'd0);
    checkOutput("rstMemAddr", bus.mem_addr, 32'd0);

    // Read word 4, accepted on the very first edge out of reset.
    memData = 32'hA5A5_5A5A;
    reset = 1'b0;
    applyStimulus(1'b1, 32'h0000_0010, 4'b0000, 32'd0);
    pulses = 0;
    tick();
    checkOutput("rdPulse", {30'd0, bus.mem_rden, bus.mem_wren}, 32'd2);
    checkOutput("rdAddr", bus.mem_addr, 32'd4);
    checkOutput("rdReadyC1", {31'd0, bus.cpu_ready}, 32'd0);
    tick();
    checkOutput("rdPulseC2", {30'd0, bus.mem_rden, bus.mem_wren}, 32'd0);
    tick();
    checkOutput("rdReadyC3", {31'd0, bus.cpu_ready}, 32'd0);
    tick();
    checkOutput("rdReadyC4", {31'd0, bus.cpu_ready}, 32'd1);
    checkOutput("rdData", bus.cpu_rdata, 32'hA5A5_5A5A);
    checkOutput("rdErr", {31'd0, bus.cpu_err}, 32'd0);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("rdReadyDrop", {31'd0, bus.cpu_ready}, 32'd0);
    checkOutput("rdDataZero", bus.cpu_rdata, 32'd0);
    checkOutput("rdPulses", pulses, 32'd1);

    // Write to the last backed word.
    pulses = 0;
    applyStimulus(1'b1, 32'h0000_FFFC, 4'b0011, 32'h1234_5678);
    tick();
    checkOutput("wrPulse", {30'd0, bus.mem_rden, bus.mem_wren}, 32'd1);
    checkOutput("wrAddr", bus.mem_addr, 32'd16383);
    checkOutput("wrStrb", {28'd0, bus.mem_wstrb}, 32'h3);
    checkOutput("wrData", bus.mem_wdata, 32'h1234_5678);
    tick(); tick();
    checkOutput("wrAddrHeld", bus.mem_addr, 32'd16383);
    tick();
    checkOutput("wrReady", {31'd0, bus.cpu_ready}, 32'd1);
    checkOutput("wrErr", {31'd0, bus.cpu_err}, 32'd0);
    checkOutput("wrRdataZero", bus.cpu_rdata, 32'd0);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("wrPulses", pulses, 32'd1);

    // First word past the backed range: immediate error, no memory access.
    pulses = 0;
    applyStimulus(1'b1, 32'h0001_0000, 4'b0000, 32'd0);
    tick();
    checkOutput("oorReady", {31'd0, bus.cpu_ready}, 32'd1);
    checkOutput("oorErr", {31'd0, bus.cpu_err}, 32'd1);
    checkOutput("oorData", bus.cpu_rdata, 32'd0);
    checkOutput("oorErrCnt", {16'd0, err_cnt}, 32'd1);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("oorErrDrop", {31'd0, bus.cpu_err}, 32'd0);
    checkOutput("oorPulses", pulses, 32'd0);

    // Silent memory: error response 15 cycles after entering WAIT, late ready ignored.
    memAuto = 0;
    applyStimulus(1'b1, 32'h0000_0020, 4'b0000, 32'd0);
    waitReady(40, lat);
    checkOutput("tmoLatency", lat, 32'd17);
    checkOutput("tmoErr", {31'd0, bus.cpu_err}, 32'd1);
    checkOutput("tmoData", bus.cpu_rdata, 32'd0);
    checkOutput("tmoErrCnt", {16'd0, err_cnt}, 32'd2);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    forceReady = 1;
    bus.mem_ready = 1'b1;
    readies = 0;
    tick(); tick(); tick();
    checkOutput("lateReadyIgnored", readies, 32'd0);
    checkOutput("lateErrCnt", {16'd0, err_cnt}, 32'd2);
    forceReady = 0;
    memAuto = 1;
    tick();

    // Configuration mode blocks acceptance; releasing it gives a normal access.
    memData = 32'hCAFE_F00D;
    pulses = 0;
    readies = 0;
    conf_sel = 1'b1;
    applyStimulus(1'b1, 32'h0000_0040, 4'b0000, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("confPulses", pulses, 32'd0);
    checkOutput("confReadies", readies, 32'd0);
    conf_sel = 1'b0;
    waitReady(20, lat);
    checkOutput("confLatency", lat, 32'd4);
    checkOutput("confData", bus.cpu_rdata, 32'hCAFE_F00D);
    checkOutput("confAddr", bus.mem_addr, 32'h10);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    tick();

    // Configuration mode raised mid-access lets the access finish, then blocks.
    pulses = 0;
    applyStimulus(1'b1, 32'h0000_0047, 4'b0000, 32'd0);
    tick();
    conf_sel = 1'b1;
    lat = 1;
    begin
      int more;
      waitReady(20, more);
      lat += more;
    end
    checkOutput("midConfLatency", lat, 32'd4);
    checkOutput("midConfAddr", bus.mem_addr, 32'h11);
    tick(); tick(); tick();
    checkOutput("midConfPulses", pulses, 32'd1);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    conf_sel = 1'b0;
    tick();

    // Reset while waiting discards the access and the memory's pending ready.
    readies = 0;
    applyStimulus(1'b1, 32'h0000_0050, 4'b0000, 32'd0);
    tick(); tick();
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("wRstReady", {31'd0, bus.cpu_ready}, 32'd0);
    checkOutput("wRstErrCnt", {16'd0, err_cnt}, 32'd0);
    checkOutput("wRstAddr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    checkOutput("wRstNoReady", readies, 32'd0);
    memData = 32'h0BAD_BEEF;
    applyStimulus(1'b1, 32'h0000_0060, 4'b0000, 32'd0);
    waitReady(20, lat);
    checkOutput("postRstLatency", lat, 32'd4);
    checkOutput("postRstData", bus.cpu_rdata, 32'h0BAD_BEEF);
    checkOutput("postRstAddr", bus.mem_addr, 32'h18);
    applyStimulus(1'b0, 32'd0, 4'd0, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
